// File: rtl/bta_operand_loader.sv
// bta_operand_loader
// Feeds the 8-operand registered binary-tree adder and collects its result.
// Operands arrive one per cycle on a valid/ready stream and are packed into
// slots A..H. A group closes after the eighth operand or after an operand
// flagged in_last. The slots then stay frozen while the tree computes. The
// tree sum is then captured and offered on a valid/ready result port.
//
// Ports:
//   clk, rst             rising-edge clock, synchronous active-high reset
//   in_valid/in_ready    operand stream handshake
//   in_data, in_last     operand value, marks the last operand of a short group
//   op_a..op_h, op_cin   parallel operands and carry-in to the tree
//   tree_sum             tree output (LAT registered stages after op_*)
//   res_valid/res_ready  result handshake
//   res_data, res_count  captured sum and number of operands in the group
//   busy                 group in flight (waiting on the tree or holding result)
module bta_operand_loader #(
  parameter int unsigned M   = 16,
  parameter int unsigned LAT = 3,
  parameter int unsigned SW  = M + 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [M-1:0]  in_data,
  input  logic          in_last,
  output logic [M-1:0]  op_a,
  output logic [M-1:0]  op_b,
  output logic [M-1:0]  op_c,
  output logic [M-1:0]  op_d,
  output logic [M-1:0]  op_e,
  output logic [M-1:0]  op_f,
  output logic [M-1:0]  op_g,
  output logic [M-1:0]  op_h,
  output logic          op_cin,
  input  logic [SW-1:0] tree_sum,
  output logic          res_valid,
  input  logic          res_ready,
  output logic [SW-1:0] res_data,
  output logic [3:0]    res_count,
  output logic          busy
);

  localparam int unsigned WCW = (LAT < 1) ? 1 : $clog2(LAT + 1);

  typedef enum logic [1:0] {
    FILL = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t         state;
  logic [3:0]     count;
  logic [WCW-1:0] wcnt;
  logic [M-1:0]   slot [8];

  logic           xfer_c;
  logic [3:0]     count_nxt_c;

  // Operand transfer: in_ready is only ever high in FILL.
  assign xfer_c      = in_valid & in_ready;
  assign count_nxt_c = count + 4'd1;

  assign op_a   = slot[0];
  assign op_b   = slot[1];
  assign op_c   = slot[2];
  assign op_d   = slot[3];
  assign op_e   = slot[4];
  assign op_f   = slot[5];
  assign op_g   = slot[6];
  assign op_h   = slot[7];
  assign op_cin = 1'b0;

  // Loader FSM with all outputs registered.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= FILL;
      count     <= 4'd0;
      wcnt      <= '0;
      for (int i = 0; i < 8; i++) slot[i] <= '0;
      in_ready  <= 1'b1;
      res_valid <= 1'b0;
      res_data  <= '0;
      res_count <= 4'd0;
      busy      <= 1'b0;
    end else begin
      case (state)
        FILL: begin
          if (xfer_c) begin
            slot[count[2:0]] <= in_data;
            count            <= count_nxt_c;
            // Close the group; unwritten slots stay zero and pad the sum.
            if (count_nxt_c == 4'd8 || in_last) begin
              state     <= WAIT;
              in_ready  <= 1'b0;
              busy      <= 1'b1;
              wcnt      <= WCW'(LAT);
              res_count <= count_nxt_c;
            end
          end
        end
        WAIT: begin
          // Counter hits zero once the tree has had LAT edges past the
          // operand registers, so tree_sum is valid here.
          if (wcnt == '0) begin
            res_data  <= tree_sum;
            res_valid <= 1'b1;
            state     <= DONE;
          end else begin
            wcnt <= wcnt - WCW'(1);
          end
        end
        DONE: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
            count     <= 4'd0;
            for (int i = 0; i < 8; i++) slot[i] <= '0;
            state     <= FILL;
          end
        end
        default: state <= FILL;
      endcase
    end
  end

endmodule

// File: tb/tb_bta_operand_loader.sv
// Scoreboard bench for bta_operand_loader with a 3-stage registered tree model.
module tb_bta_operand_loader;

  localparam int unsigned M   = 16;
  localparam int unsigned LAT = 3;
  localparam int unsigned SW  = M + 3;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [M-1:0]  in_data = '0;
  logic          in_last = 1'b0;
  logic [M-1:0]  op_a, op_b, op_c, op_d, op_e, op_f, op_g, op_h;
  logic          op_cin;
  logic [SW-1:0] tree_sum;
  logic          res_valid;
  logic          res_ready = 1'b1;
  logic [SW-1:0] res_data;
  logic [3:0]    res_count;
  logic          busy;

  bta_operand_loader #(.M(M), .LAT(LAT), .SW(SW)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
    .op_a(op_a), .op_b(op_b), .op_c(op_c), .op_d(op_d),
    .op_e(op_e), .op_f(op_f), .op_g(op_g), .op_h(op_h),
    .op_cin(op_cin), .tree_sum(tree_sum),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_data(res_data), .res_count(res_count), .busy(busy)
  );

  always #5 clk = ~clk;

  // Registered binary tree: pairs, quads, total (three stages).
  logic [SW-1:0] s1 [4];
  logic [SW-1:0] s2 [2];
  logic [M-1:0]  ops [8];
  assign ops[0] = op_a; assign ops[1] = op_b; assign ops[2] = op_c; assign ops[3] = op_d;
  assign ops[4] = op_e; assign ops[5] = op_f; assign ops[6] = op_g; assign ops[7] = op_h;

  always @(posedge clk) begin
    for (int i = 0; i < 4; i++) s1[i] <= SW'(ops[2*i]) + SW'(ops[2*i+1]);
    for (int i = 0; i < 2; i++) s2[i] <= s1[2*i] + s1[2*i+1];
    tree_sum <= s2[0] + s2[1];
  end

  typedef struct packed {
    logic [SW-1:0] sum;
    logic [3:0]    cnt;
  } exp_t;

  exp_t sb [$];
  int   n_cmp  = 0;
  int   n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every accepted result is matched against the oldest expectation.
  always @(negedge clk) begin
    if (!rst && res_valid && res_ready) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL unexpected_result: got data 0x%0h count %0d with nothing expected",
                 res_data, res_count);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("res_data", 32'(res_data), 32'(e.sum));
        check("res_count", 32'(res_count), 32'(e.cnt));
      end
    end
  end

  // Present one operand and hold it until it is taken.
  task automatic send(input logic [M-1:0] d, input logic l);
    logic ok;
    ok = 1'b0;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = l;
    for (int k = 0; k < 50; k++) begin
      ok = in_ready;
      @(posedge clk); #1;
      if (ok) break;
    end
    if (!ok) begin
      n_cmp++;
      n_fail++;
      $display("FAIL send_timeout: operand 0x%0h never accepted", d);
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic wait_idle();
    int k;
    for (k = 0; k < 50; k++) begin
      if (in_ready && !res_valid) break;
      @(posedge clk); #1;
    end
    if (k == 50) begin
      n_cmp++;
      n_fail++;
      $display("FAIL idle_timeout: in_ready %0b res_valid %0b", in_ready, res_valid);
    end
  endtask

  initial begin
    int first_valid;
    int n_low;
    logic [SW-1:0] held;

    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_res_valid", 32'(res_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_res_data", 32'(res_data), 32'd0);
    check("rst_res_count", 32'(res_count), 32'd0);
    check("rst_op_a", 32'(op_a), 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // in_last without in_valid must not close anything.
    in_last = 1'b1;
    @(posedge clk); #1;
    in_last = 1'b0;
    check("lone_last_in_ready", 32'(in_ready), 32'd1);

    // 1..8 back to back: latency and in_ready low time.
    sb.push_back('{sum: SW'(36), cnt: 4'd8});
    for (int i = 1; i <= 8; i++) send(M'(i), 1'b0);
    check("t1_op_a", 32'(op_a), 32'd1);
    check("t1_op_h", 32'(op_h), 32'd8);
    check("t1_busy", 32'(busy), 32'd1);
    first_valid = 0;
    n_low = in_ready ? 0 : 1;
    for (int k = 1; k <= 8; k++) begin
      @(posedge clk); #1;
      if (!in_ready) n_low++;
      if (res_valid && first_valid == 0) first_valid = k;
    end
    check("t1_latency", 32'(first_valid), 32'd4);
    check("t1_in_ready_low", 32'(n_low), 32'd5);
    wait_idle();

    // Full-scale operands: no truncation.
    sb.push_back('{sum: SW'(19'h7FFF8), cnt: 4'd8});
    for (int i = 0; i < 8; i++) send(16'hFFFF, 1'b0);
    wait_idle();

    // Short group padded with zeros.
    sb.push_back('{sum: SW'(60), cnt: 4'd3});
    send(16'd10, 1'b0);
    send(16'd20, 1'b0);
    send(16'd30, 1'b1);
    check("t3_op_c", 32'(op_c), 32'd30);
    check("t3_pad_zero", 32'(op_d | op_e | op_f | op_g | op_h), 32'd0);
    wait_idle();

    // Back-pressure on the result port.
    res_ready = 1'b0;
    sb.push_back('{sum: SW'(1000), cnt: 4'd4});
    send(16'd100, 1'b0);
    send(16'd200, 1'b0);
    send(16'd300, 1'b0);
    send(16'd400, 1'b1);
    for (int k = 0; k < 20; k++) begin
      if (res_valid) break;
      @(posedge clk); #1;
    end
    check("t4_res_valid", 32'(res_valid), 32'd1);
    held = res_data;
    check("t4_held_value", 32'(held), 32'd1000);
    for (int k = 0; k < 6; k++) begin
      in_valid = (k % 2) == 0;
      in_data  = 16'hBEEF;
      @(posedge clk); #1;
      check("t4_hold_data", 32'(res_data), 32'(held));
      check("t4_hold_in_ready", 32'(in_ready), 32'd0);
      check("t4_hold_valid", 32'(res_valid), 32'd1);
    end
    in_valid  = 1'b0;
    res_ready = 1'b1;
    sb.push_back('{sum: SW'(15), cnt: 4'd2});
    send(16'd7, 1'b0);
    send(16'd8, 1'b1);
    check("t4_next_op_a", 32'(op_a), 32'd7);
    check("t4_next_op_b", 32'(op_b), 32'd8);
    check("t4_next_op_c", 32'(op_c), 32'd0);
    wait_idle();

    // Reset on the second WAIT cycle discards the group.
    send(16'd1, 1'b0);
    send(16'd1, 1'b0);
    send(16'd1, 1'b1);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("t5_in_ready", 32'(in_ready), 32'd1);
    check("t5_busy", 32'(busy), 32'd0);
    check("t5_res_valid", 32'(res_valid), 32'd0);
    check("t5_res_data", 32'(res_data), 32'd0);
    check("t5_res_count", 32'(res_count), 32'd0);
    check("t5_ops_zero", 32'(op_a | op_b | op_c | op_d | op_e | op_f | op_g | op_h), 32'd0);
    sb.push_back('{sum: SW'(40), cnt: 4'd8});
    for (int i = 0; i < 8; i++) send(16'd5, 1'b0);
    wait_idle();

    // Single operand group.
    sb.push_back('{sum: SW'(16'h1234), cnt: 4'd1});
    send(16'h1234, 1'b1);
    check("t6_op_cin", 32'(op_cin), 32'd0);
    check("t6_busy", 32'(busy), 32'd1);
    wait_idle();
    check("t6_op_cin_idle", 32'(op_cin), 32'd0);

    repeat (4) @(posedge clk);
    #1;
    check("sb_drained", 32'(sb.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  // Global watchdog.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule

// File: doc/bta_operand_loader.md
Name: bta_operand_loader

Overview:
- Upstream feeder and result collector for the 8-operand binary-tree adder (BTA_CLA_8 class, M-bit operands, registered CLA stages).
- Accepts operands one per cycle over a valid/ready stream and packs them into eight parallel slots, A..H.
- Holds the slots stable while the registered tree computes, then captures the tree sum and presents it on a valid/ready result port.

Parameters:
- M, 16, operand width in bits.
- LAT, 3, tree latency: number of registered adder stages between operand inputs and sum (3 for the 8-operand tree).
- SW, M+3, sum width; must equal the tree output width.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  operand available.
- in_ready  output  1  loader can accept an operand.
- in_data  input  M  operand value.
- in_last  input  1  qualifies the final operand of a group of fewer than 8.
- op_a..op_h  output  M each  parallel operands to tree inputs A..H.
- op_cin  output  1  carry-in to tree (C0); constant 0.
- tree_sum  input  SW  tree sum output.
- res_valid  output  1  result available.
- res_ready  input  1  consumer accepts result.
- res_data  output  SW  captured sum.
- res_count  output  4  operands in this group, 1..8.
- busy  output  1  high in WAIT or DONE.

Behaviour:
- Reset, synchronous, any state:
  - state=FILL, slot count=0.
  - op_a..op_h=0, res_data=0, res_count=0, res_valid=0, busy=0.
  - in_ready=1 from the first cycle after reset.
- States: FILL, WAIT, DONE.
- FILL:
  - in_ready=1.
  - Transfer occurs when in_valid&in_ready; in_data is written to slot[count] (A=first, H=eighth) and count increments.
  - Transition to WAIT on the transfer edge when that transfer makes count=8 or carries in_last=1.
  - res_count=count after the transfer.
  - Unwritten slots remain 0, which pads short groups.
  - in_last without in_valid is ignored.
- WAIT:
  - in_ready=0, busy=1; op_* held stable.
  - wait counter loads LAT on entry and decrements each cycle.
  - On the edge where the counter reads 0, tree_sum is registered into res_data and state becomes DONE.
  - WAIT therefore lasts exactly LAT+1 cycles, giving the tree LAT edges to propagate after the operands are registered.
- DONE:
  - res_valid=1, in_ready=0, busy=1.
  - res_data and res_count held until res_valid&res_ready.
  - On acceptance, in the same edge: op_* cleared to 0, count=0, res_valid=0, state returns to FILL.
- Latency: last operand transfer edge to res_valid high is LAT+1 cycles; for LAT=3 that is 4 cycles.
- Throughput: one group per (N+LAT+2) cycles minimum. Groups do not overlap.
- Width: full sum of 8 M-bit operands fits in SW=M+3 bits. Maximum is 8*(2^M-1); no overflow is possible, so no carry output is required.
- op_cin is tied to 0 at all times.
- Simultaneous events:
  - in_valid during WAIT or DONE: not accepted and data not stored; the source must hold.
  - in_last on the 8th operand: same as no in_last.
- Reset mid-WAIT or mid-DONE: the group is discarded, no res_valid pulse occurs, and the loader returns to FILL. The tree pipeline contents are don't-care.

Test Plan:
- Operands 1,2,…,8 back-to-back with res_ready=1 → res_valid rises 4 cycles after 8th transfer; res_data=36, res_count=8; in_ready low for 5 cycles total.
- Eight operands of 0xFFFF → res_data=0x7FFF8, res_count=8; no truncation.
- Operands 10,20,30 with in_last on 30 → op_d..op_h=0 during WAIT; res_data=60, res_count=3.
- res_ready held low 6 cycles after res_valid → res_data stable, in_ready=0, in_valid pulses ignored; release res_ready → next group starts from slot A and the following result is correct.
- rst asserted on the 2nd WAIT cycle → next cycle all outputs 0, state FILL, in_ready=1; no res_valid for the aborted group; following group 5,5,5,5,5,5,5,5 gives 40.
- Single operand 0x1234 with in_last → res_data=0x1234, res_count=1, op_cin=0 throughout.
